// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and opcode-class helpers shared by the
// multicycle ALU and its iterative multiply/divide unit.
package alu_pkg;

  // 4-bit ALUControl encodings
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_MUL   = 4'b0100;
  localparam logic [3:0] ALU_MULHU = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_DIVU  = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // True for the opcodes that go through the multi-cycle mul/div unit
  function automatic logic is_iterative(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) ||
           (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // True for the opcodes that run the restoring divider
  function automatic logic is_divide(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // True when the result is the upper half of the accumulator
  // (product high word, or division remainder)
  function automatic logic is_high_half(input logic [3:0] op);
    return (op == ALU_MULHU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared shift-add multiplier / restoring divider.
// One 2*WIDTH accumulator holds {high, low}: for multiply it ends as the full
// product, for divide as {remainder, quotient}. UNROLL bits per cycle.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_next_o
);

  localparam int ITERS = WIDTH / UNROLL;
  localparam int CW    = $clog2(ITERS);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic               active_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     partial;
  logic [WIDTH-1:0]   trial;

  // Next accumulator value after UNROLL multiply or divide steps
  always_comb begin
    acc_d   = acc_q;
    partial = '0;
    trial   = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (div_q) begin
        partial = {acc_d[2*WIDTH-1:WIDTH], acc_d[WIDTH-1]};
        trial   = partial[WIDTH-1:0] - opnd_q;
        if (partial >= {1'b0, opnd_q}) begin
          acc_d = {trial, acc_d[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {partial[WIDTH-1:0], acc_d[WIDTH-2:0], 1'b0};
        end
      end else begin
        partial = {1'b0, acc_d[2*WIDTH-1:WIDTH]} +
                  ({1'b0, opnd_q} & {(WIDTH+1){acc_d[0]}});
        acc_d   = {partial, acc_d[WIDTH-1:1]};
      end
    end
  end

  // Load operands on start, then step until the counter has run out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= {{WIDTH{1'b0}}, a_i};
      opnd_q   <= b_i;
      div_q    <= div_i;
      active_q <= 1'b1;
      cnt_q    <= CW'(ITERS - 1);
    end else if (active_q) begin
      acc_q <= acc_d;
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign last_o     = active_q && (cnt_q == '0);
  assign acc_next_o = acc_d;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with valid/ready handshakes. Single-cycle ops
// complete in one cycle; mul/mulhu/divu/remu iterate in alu_muldiv_iter.
// Optional feature macro: ALU_OVF_FLAG_EN adds a signed-overflow flag 'ovf'
// for add/sub, registered alongside 'out'.
// WIDTH must be even and >= 8; UNROLL must be 1, 2 or 4 and divide WIDTH.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef ALU_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   out_q;
  logic               hi_sel_q;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     shamt;
  logic               accept;
  logic               md_start;
  logic               md_last;
  logic [2*WIDTH-1:0] md_acc_next;
`ifdef ALU_OVF_FLAG_EN
  logic               ovf_q;
  logic               sc_ovf;
`endif

  assign sum      = in1 + in2;
  assign diff     = in1 - in2;
  assign shamt    = in2[SHW-1:0];
  assign accept   = in_ready_q && in_valid;
  assign md_start = accept && is_iterative(alu_ctrl);

  // Combinational single-cycle ALU; iterative and undefined codes give 0
  always_comb begin
    sc_res = '0;
    case (alu_ctrl)
      ALU_ADD:  sc_res = sum;
      ALU_SUB:  sc_res = diff;
      ALU_AND:  sc_res = in1 & in2;
      ALU_OR:   sc_res = in1 | in2;
      ALU_XOR:  sc_res = in1 ^ in2;
      ALU_NOR:  sc_res = ~(in1 | in2);
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      ALU_SLL:  sc_res = in1 << shamt;
      ALU_SRL:  sc_res = in1 >> shamt;
      ALU_SRA:  sc_res = $signed(in1) >>> shamt;
      default:  sc_res = '0;
    endcase
  end

`ifdef ALU_OVF_FLAG_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result's sign departs from in1
  always_comb begin
    sc_ovf = 1'b0;
    if (alu_ctrl == ALU_ADD) begin
      sc_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
    end else if (alu_ctrl == ALU_SUB) begin
      sc_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
    end
  end
`endif

  alu_muldiv_iter #(
    .WIDTH  (WIDTH),
    .UNROLL (UNROLL)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (md_start),
    .div_i      (is_divide(alu_ctrl)),
    .a_i        (in1),
    .b_i        (in2),
    .last_o     (md_last),
    .acc_next_o (md_acc_next)
  );

  // Handshake FSM with registered outputs: IDLE accepts, BUSY iterates,
  // DONE holds the result until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      hi_sel_q    <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (is_iterative(alu_ctrl)) begin
              state_q  <= BUSY;
              busy_q   <= 1'b1;
              hi_sel_q <= is_high_half(alu_ctrl);
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_q       <= sc_res;
`ifdef ALU_OVF_FLAG_EN
              ovf_q       <= sc_ovf;
`endif
            end
          end
        end
        BUSY: begin
          if (md_last) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_q       <= hi_sel_q ? md_acc_next[2*WIDTH-1:WIDTH]
                                    : md_acc_next[WIDTH-1:0];
`ifdef ALU_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;
`ifdef ALU_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: table-driven vectors with an expected-result queue,
// plus hand-written backpressure and reset-mid-divide sequences.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [3:0]  alu_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        busy;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        expOvf;
    int          lat;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] expQ[$];

  alu_multicycle #(.WIDTH(32), .UNROLL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
`ifdef ALU_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Watchdog so the bench can never hang
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input logic expOvf, input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.expOvf = expOvf; v.name = name;
    v.lat = is_iterative(op) ? 33 : 1;
    return v;
  endfunction

  // Present an op at the negedge and hold it until the accepting posedge
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int waitCycles;
    @(negedge clk);
    alu_ctrl = op; in1 = a; in2 = b; in_valid = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 100) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout actual=%0d required=<100", waitCycles);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency and value against the queue, then handshake
  task automatic checkOutput(input string name, input int expLat, input logic iter, input logic expOvf);
    int lat;
    logic sawReady;
    logic [31:0] exp;
    lat = 1;
    sawReady = 1'b0;
    if (iter) checkVal({name, "_busy"}, 32'(busy), 32'd1);
    while (!out_valid && lat < 200) begin
      if (in_ready) sawReady = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal({name, "_latency"}, 32'(lat), 32'(expLat));
    if (iter) checkVal({name, "_in_ready_low"}, 32'(sawReady), 32'd0);
    if (expQ.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL %s_queue actual=empty required=entry", name);
    end else begin
      exp = expQ.pop_front();
      checkVal(name, out, exp);
    end
`ifdef ALU_OVF_FLAG_EN
    checkVal({name, "_ovf"}, 32'(ovf), 32'(expOvf));
`else
    if (expOvf === 1'bx) $display("[TB] unexpected ovf expectation");
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkVal({name, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int sawValid;

    // Vector table
    vecs.push_back(mkVec(ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, "add_ovf"));
    vecs.push_back(mkVec(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max"));
    vecs.push_back(mkVec(ALU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, "mul_max"));
    vecs.push_back(mkVec(ALU_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, "divu_by0"));
    vecs.push_back(mkVec(ALU_REMU,  32'd100,      32'd0,        32'd100,      1'b0, "remu_by0"));
    vecs.push_back(mkVec(ALU_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7"));
    vecs.push_back(mkVec(ALU_REMU,  32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7"));
    vecs.push_back(mkVec(ALU_SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1'b0, "sll_mask"));
    vecs.push_back(mkVec(ALU_SRA,   32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, "sra_31"));
    vecs.push_back(mkVec(ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, "slt_neg"));
    vecs.push_back(mkVec(ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "sltu_big"));
    vecs.push_back(mkVec(ALU_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, "sub_wrap"));
    vecs.push_back(mkVec(ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, "sub_ovf"));
    vecs.push_back(mkVec(ALU_AND,   32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, "and"));
    vecs.push_back(mkVec(ALU_OR,    32'hF0F00000, 32'h0F0F0001, 32'hFFFF0001, 1'b0, "or"));
    vecs.push_back(mkVec(ALU_XOR,   32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, "xor"));
    vecs.push_back(mkVec(ALU_NOR,   32'hF0000000, 32'h0000000F, 32'h0FFFFFF0, 1'b0, "nor"));
    vecs.push_back(mkVec(ALU_SRL,   32'h80000000, 32'h00000024, 32'h08000000, 1'b0, "srl_mask"));
    vecs.push_back(mkVec(4'b1101,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, "undef"));
    vecs.push_back(mkVec(ALU_MUL,   32'd12345,    32'd678,      32'd8369910,  1'b0, "mul_small"));
    vecs.push_back(mkVec(ALU_DIVU,  32'hFFFFFFFF, 32'd3,        32'h55555555, 1'b0, "divu_max_3"));
    vecs.push_back(mkVec(ALU_REMU,  32'd1000,     32'd3,        32'd1,        1'b0, "remu_1000_3"));

    // Reset held for two cycles, then reset-state checks
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_state", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    checkVal("reset_out", out, 32'h0);
    rst_n = 1'b1;

    // Table-driven run
    foreach (vecs[i]) begin
      expQ.push_back(vecs[i].exp);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput(vecs[i].name, vecs[i].lat, is_iterative(vecs[i].op), vecs[i].expOvf);
    end

    // Backpressure: hold out_ready low, offer a new op meanwhile
    expQ.push_back(32'd11);
    applyStimulus(ALU_ADD, 32'd5, 32'd6);
    checkVal("bp_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    alu_ctrl = ALU_SUB; in1 = 32'd9; in2 = 32'd9; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkVal("bp_hold", {out[30:0], in_ready}, {31'd11, 1'b0});
    end
    in_valid = 1'b0;
    checkOutput("bp_result", 1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkVal("bp_no_accept", 32'(out_valid), 32'd0);

    // Reset mid-divide: discard the in-flight operation
    applyStimulus(ALU_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    checkVal("mid_busy", {30'd0, busy, in_ready}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkVal("mid_reset", {29'd0, in_ready, busy, out_valid}, 32'd4);
    sawValid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid++;
    end
    checkVal("mid_no_valid", 32'(sawValid), 32'd0);

    // Recovery after the aborted divide
    expQ.push_back(32'd14);
    applyStimulus(ALU_DIVU, 32'd100, 32'd7);
    checkOutput("post_reset_divu", 33, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
